fir_ntap_pipe: RTL
==================

Name: fir_ntap_pipe

Overview:
Parametrised, fully pipelined N-tap FIR filter for the ADC sample path. It is the successor to the fixed 8-tap filter and adds:
- configurable tap count, data width and coefficient width;
- signed coefficients with rounding and clamping;
- a double-buffered coefficient bank that can be reloaded at run time;
- a sample-valid qualifier;
- a bypass path that keeps the same latency as the filtered path.

It sits between the ADC sample capture and the downstream processing/readout logic.

Parameters:
NTAPS, 8, number of taps (2..32)
DW, 12, input/output sample width, unsigned
CW, 16, coefficient width, signed two's complement
SHIFT, 13, coefficient fractional bits; result is divided by 2^SHIFT
AW, 5, coefficient address width; must satisfy 2^AW >= NTAPS

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
ENABLE_FIR  in  1  1 = filter, 0 = bypass; sampled with each valid input sample
DATA_IN  in  DW  input sample, unsigned
DATA_IN_VALID  in  1  DATA_IN is a new sample this cycle
COEFF_WE  in  1  write COEFF_DATA into shadow bank at COEFF_ADDR
COEFF_ADDR  in  AW  tap index; 0 = newest sample
COEFF_DATA  in  CW  coefficient value, signed
COEFF_LOAD  in  1  one-cycle pulse: copy shadow bank into active bank
DATA_OUT  out  DW  filtered or bypassed sample
DATA_OUT_VALID  out  1  DATA_OUT is valid this cycle
OVERFLOW  out  1  with DATA_OUT_VALID: the result was clamped

Behaviour:
- Latency: L = 3 + ceil(log2(NTAPS)) cycles from DATA_IN_VALID to DATA_OUT_VALID. L = 6 for NTAPS=8.
- One sample is accepted per cycle. There is no backpressure.
- Pipeline stages:
  - S1: delay line shifts only when DATA_IN_VALID=1. Tap0 <= DATA_IN, tap k <= tap k-1.
  - S2: registered products tap_k (zero-extended, signed) * active_coeff_k.
  - S3..S(L-1): registered pairwise adder tree, full precision. Accumulator width is DW+CW+ceil(log2(NTAPS))+1 bits, signed, so no internal overflow is possible.
  - SL: add 2^(SHIFT-1) (round half up), arithmetic shift right by SHIFT, clamp to [0, 2^DW-1], register.
- The valid, ENABLE_FIR and raw-sample bits travel down the pipeline alongside the data.
  - Bypass (ENABLE_FIR=0 at input): DATA_OUT = raw DATA_IN delayed by L, OVERFLOW=0.
  - Mode changes therefore take effect on a per-sample boundary with no glitches.
  - The delay line keeps shifting in bypass, so filtered output resumes with correct history.
- When DATA_OUT_VALID=0, DATA_OUT and OVERFLOW hold their previous values.
- OVERFLOW=1 iff the rounded value was < 0 or > 2^DW-1 for that sample.
- Coefficient banks:
  - COEFF_WE writes the shadow bank only. COEFF_ADDR >= NTAPS is ignored.
  - COEFF_LOAD copies all shadow taps into the active bank at the next edge.
  - Samples whose products are formed in S2 after that edge use the new set. Older samples in flight complete with the old set.
  - COEFF_WE and COEFF_LOAD in the same cycle: the write lands in shadow first and the load copies the updated value.
- RESET (synchronous, active-high; any cycle, including mid-stream):
  - clears the delay line, all pipeline registers and valid bits;
  - sets DATA_OUT=0, DATA_OUT_VALID=0, OVERFLOW=0;
  - sets both banks to identity: coeff0 = 2^SHIFT, others 0.
  - Inputs on the reset cycle are ignored. The first valid output appears L cycles after the first post-reset DATA_IN_VALID.
- Gaps in DATA_IN_VALID do not advance the filter state. Output timing is still L cycles after each valid input.

Test Plan:
- Reset identity: RESET, then DATA_IN=1234 with valid -> DATA_OUT=1234, DATA_OUT_VALID=1 exactly 6 cycles later, OVERFLOW=0.
- Impulse response:
  - Stimulus: load c_k=400*(k+1) for k=0..7, pulse COEFF_LOAD, input 2048 followed by seven zeros, all valid.
  - Required: outputs 100,200,...,800 on consecutive cycles.
- Rounding and clamping:
  - coeff0=4096, input 3 -> DATA_OUT=2, OVERFLOW=0.
  - All coeffs 8192, DC input 4095 -> DATA_OUT=4095, OVERFLOW=1.
  - coeff0=-8192, input 100 -> DATA_OUT=0, OVERFLOW=1.
- Shadow bank and swap:
  - Stimulus: stream a DC level of 1000; write a new bank mid-stream; pulse COEFF_LOAD at cycle T.
  - Required: outputs unchanged through the writes. Outputs from samples entering S2 after T reflect the new coefficients.
- Bypass and gaps:
  - Toggle ENABLE_FIR per sample with DATA_IN_VALID gaps -> bypassed samples equal DATA_IN delayed by 6 cycles. Filtered samples match a reference model that uses the valid-only history.
- Reset mid-stream: assert RESET while samples are in flight -> DATA_OUT_VALID=0 next cycle, no stale output emerges later, and coefficients return to identity.

Source files
------------

// File: rtl/fir_ntap_pipe.sv
// Fully pipelined N-tap FIR for the ADC sample path: double-buffered signed coefficients,
// round-half-up with clamping, and a bypass that matches the filtered path's latency.
module fir_ntap_pipe #(
  parameter int unsigned NTAPS = 8,
  parameter int unsigned DW    = 12,
  parameter int unsigned CW    = 16,
  parameter int unsigned SHIFT = 13,
  parameter int unsigned AW    = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE_FIR,
  input  logic [DW-1:0] DATA_IN,
  input  logic          DATA_IN_VALID,
  input  logic          COEFF_WE,
  input  logic [AW-1:0] COEFF_ADDR,
  input  logic [CW-1:0] COEFF_DATA,
  input  logic          COEFF_LOAD,
  output logic [DW-1:0] DATA_OUT,
  output logic          DATA_OUT_VALID,
  output logic          OVERFLOW
);

  localparam int unsigned Log2  = $clog2(NTAPS);
  localparam int unsigned NPad  = 1 << Log2;
  localparam int unsigned Lat   = 3 + Log2;
  localparam int unsigned NMeta = Lat - 1;
  localparam int unsigned PW    = DW + CW + 1;
  localparam int unsigned AccW  = DW + CW + Log2 + 1;

  localparam logic [CW-1:0]          CoeffUnity = {{(CW-1){1'b0}}, 1'b1} << SHIFT;
  localparam logic signed [AccW-1:0] RoundK     = {{(AccW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [AccW-1:0] MaxOut     = {{(AccW-DW){1'b0}}, {DW{1'b1}}};

  // Arrays are padded to a power of two; padding taps carry zero coefficients forever,
  // so the adder tree stays a regular binary tree.
  logic [DW-1:0]          taps_q   [NPad];
  logic [CW-1:0]          shadow_q [NPad];
  logic [CW-1:0]          shadow_d [NPad];
  logic [CW-1:0]          active_q [NPad];
  logic signed [PW-1:0]   prod_d   [NPad];
  // Heap-ordered tree: leaves NPad..2*NPad-1 hold the products, node 1 is the root.
  logic signed [AccW-1:0] tree_q   [1:2*NPad-1];

  logic                   vld_q [NMeta];
  logic                   en_q  [NMeta];
  logic [DW-1:0]          raw_q [NMeta];

  logic signed [AccW-1:0] rounded;
  logic signed [AccW-1:0] shifted;
  logic [DW-1:0]          out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   out_vld_q;

  // Coefficient banks: the write lands in the shadow first, so a same-cycle load sees it.
  always_comb begin
    for (int k = 0; k < NPad; k++) begin
      shadow_d[k] = shadow_q[k];
      if (COEFF_WE && (k < NTAPS) && (COEFF_ADDR == AW'(k))) begin
        shadow_d[k] = COEFF_DATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NPad; k++) begin
        shadow_q[k] <= (k == 0) ? CoeffUnity : '0;
        active_q[k] <= (k == 0) ? CoeffUnity : '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (COEFF_LOAD) begin
        active_q <= shadow_d;
      end
    end
  end

  // S1: delay line advances only on valid samples, in both filter and bypass mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NPad; k++) begin
        taps_q[k] <= '0;
      end
    end else if (DATA_IN_VALID) begin
      taps_q[0] <= DATA_IN;
      for (int k = 1; k < NPad; k++) begin
        taps_q[k] <= taps_q[k-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NPad; k++) begin
      prod_d[k] = PW'($signed({1'b0, taps_q[k]})) * PW'($signed(active_q[k]));
    end
  end

  // S2 products and S3..S(L-1) adder tree, registered every cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int n = 1; n < 2 * NPad; n++) begin
        tree_q[n] <= '0;
      end
    end else begin
      for (int k = 0; k < NPad; k++) begin
        tree_q[NPad+k] <= AccW'(prod_d[k]);
      end
      for (int n = 1; n < NPad; n++) begin
        tree_q[n] <= tree_q[2*n] + tree_q[2*n+1];
      end
    end
  end

  // Sideband pipeline S1..S(L-1) keeps valid, mode and raw sample aligned with the data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NMeta; i++) begin
        vld_q[i] <= 1'b0;
        en_q[i]  <= 1'b0;
        raw_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= DATA_IN_VALID;
      en_q[0]  <= ENABLE_FIR;
      raw_q[0] <= DATA_IN;
      for (int i = 1; i < NMeta; i++) begin
        vld_q[i] <= vld_q[i-1];
        en_q[i]  <= en_q[i-1];
        raw_q[i] <= raw_q[i-1];
      end
    end
  end

  assign rounded = tree_q[1] + RoundK;
  assign shifted = rounded >>> SHIFT;

  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    if (vld_q[NMeta-1]) begin
      if (!en_q[NMeta-1]) begin
        out_d = raw_q[NMeta-1];
        ovf_d = 1'b0;
      end else if (shifted[AccW-1]) begin
        out_d = '0;
        ovf_d = 1'b1;
      end else if (shifted > MaxOut) begin
        out_d = {DW{1'b1}};
        ovf_d = 1'b1;
      end else begin
        out_d = shifted[DW-1:0];
        ovf_d = 1'b0;
      end
    end
  end

  // SL: output register holds its value between valid samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      out_vld_q <= vld_q[NMeta-1];
    end
  end

  assign DATA_OUT       = out_q;
  assign OVERFLOW       = ovf_q;
  assign DATA_OUT_VALID = out_vld_q;

endmodule
